// File: rtl/ntt_arbiter.sv
// Round-robin arbiter sharing one NTT/INTT core among N_REQ requesters.
// Define NTT_ARB_TIMEOUT_EN to compile in the WAIT-state watchdog.
module ntt_arbiter #(
    parameter int N_REQ          = 4,
    parameter int SLOT_W         = 3,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_is_ntt,
    input  logic [N_REQ*SLOT_W-1:0] req_slot,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic                    core_start,
    output logic                    core_is_ntt,
    output logic [SLOT_W-1:0]       core_slot,
    input  logic                    core_done,
    output logic                    busy,
    output logic                    err_timeout
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RELEASE
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               is_ntt_q, is_ntt_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;

    logic               pick_ok;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_ntt;
    logic [SLOT_W-1:0]  pick_slot;
    logic [PTR_W:0]     sum;
    logic               timeout;

    // Scan offsets from high to low so the smallest offset from rr_ptr wins.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = '0;
        sum      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N_REQ))
                sum = sum - (PTR_W+1)'(N_REQ);
            if (req[sum[PTR_W-1:0]]) begin
                pick_ok  = 1'b1;
                pick_idx = sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        pick_ntt  = 1'b0;
        pick_slot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == PTR_W'(i)) begin
                pick_ntt  = req_is_ntt[i];
                pick_slot = req_slot[i*SLOT_W +: SLOT_W];
            end
        end
    end

`ifdef NTT_ARB_TIMEOUT_EN
    logic [9:0] wd_q, wd_d;
    logic       err_q, err_d;

    always_comb begin
        wd_d = wd_q;
        if (state_q == S_START)
            wd_d = '0;
        else if (state_q == S_WAIT)
            wd_d = wd_q + 10'd1;
    end

    assign timeout = (state_q == S_WAIT) && !core_done &&
                     (wd_q + 10'd1 == 10'(TIMEOUT_CYCLES));
    assign err_d   = err_q | timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        gnt_d    = gnt_q;
        is_ntt_d = is_ntt_q;
        slot_d   = slot_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_ok) begin
                    state_d  = S_START;
                    win_d    = pick_idx;
                    gnt_d    = N_REQ'(1) << pick_idx;
                    is_ntt_d = pick_ntt;
                    slot_d   = pick_slot;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (core_done || timeout)
                    state_d = S_RELEASE;
            end
            S_RELEASE: begin
                state_d  = S_IDLE;
                gnt_d    = '0;
                rr_ptr_d = (win_q == PTR_W'(N_REQ - 1)) ?
                           '0 : win_q + PTR_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            gnt_q    <= '0;
            is_ntt_q <= 1'b0;
            slot_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            is_ntt_q <= is_ntt_d;
            slot_q   <= slot_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = (state_q == S_RELEASE) ? gnt_q : '0;
    assign core_start  = (state_q == S_START);
    assign busy        = (state_q != S_IDLE);
    assign core_is_ntt = is_ntt_q;
    assign core_slot   = slot_q;

endmodule
